// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: per-stage payload widths, the stage-register
// state encoding and the bubble (NOP) payload for each inter-stage register.
// Stage wrappers pack their fields into these payload widths; a NOP payload
// is all zeros so that write enables and halt in a bubble read back as 0.
package pipe_stage_reg_pkg;

  localparam int FD_PAYLOAD_W = 64;
  localparam int DX_PAYLOAD_W = 128;
  localparam int XM_PAYLOAD_W = 112;
  localparam int MW_PAYLOAD_W = 80;

  localparam logic [FD_PAYLOAD_W-1:0] FD_NOP = '0;
  localparam logic [DX_PAYLOAD_W-1:0] DX_NOP = '0;
  localparam logic [XM_PAYLOAD_W-1:0] XM_NOP = '0;
  localparam logic [MW_PAYLOAD_W-1:0] MW_NOP = '0;

  // Value doubles as the occupancy count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pipe_stage_reg_register.sv
// Generic enabled register with synchronous active-high reset.
//   clk : rising-edge clock
//   rst : synchronous reset, loads RST_VALUE (wins over en)
//   en  : load d
//   d/q : SIZE-bit data in / registered data out
module pipe_stage_reg_register #(
  parameter int              SIZE      = 1,
  parameter logic [SIZE-1:0] RST_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VALUE;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register carrying one packed payload.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous kill of every held entry (same as reset)
//   in_valid/in_ready : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload
//   occupancy         : entries held after the last edge (0..2)
// SKID=1 adds a second entry so in_ready comes straight from a flop;
// SKID=0 holds one entry and in_ready is combinational.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Flush behaves exactly like reset on every piece of state.
  logic kill;
  assign kill = rst | flush;

  logic [1:0]       state_q;
  ps_state_e        state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_en, skid_en;
  logic             rdy_q;
  logic             in_fire;

  assign state     = ps_state_e'(state_q);
  assign out_valid = (state != PS_EMPTY);
  // main is reloaded with NOP whenever the stage empties, so no output mux.
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_ready  = SKID ? rdy_q : (~out_valid | out_ready);
  assign in_fire   = in_valid & in_ready;

  // With SKID=0 the TWO branch is unreachable: in ONE, in_ready equals
  // out_ready, so a push always coincides with a pop.
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = in_data;
    skid_en   = 1'b0;
    unique case (state)
      PS_EMPTY: begin
        if (in_fire) begin
          state_nxt = PS_ONE;
          main_en   = 1'b1;
        end
      end
      PS_ONE: begin
        if (in_fire && out_ready) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_nxt = PS_TWO;
          skid_en   = 1'b1;
        end else if (out_ready) begin
          state_nxt = PS_EMPTY;
          main_en   = 1'b1;
          main_d    = NOP_VALUE;
        end
      end
      PS_TWO: begin
        if (out_ready) begin
          state_nxt = PS_ONE;
          main_en   = 1'b1;
          main_d    = skid_q;
        end
      end
      default: state_nxt = PS_EMPTY;
    endcase
  end

  pipe_stage_reg_register #(.SIZE(2), .RST_VALUE(PS_EMPTY)) u_state (
    .clk(clk), .rst(kill), .en(1'b1), .d(state_nxt), .q(state_q)
  );

  pipe_stage_reg_register #(.SIZE(WIDTH), .RST_VALUE(NOP_VALUE)) u_main (
    .clk(clk), .rst(kill), .en(main_en), .d(main_d), .q(main_q)
  );

  // Skid entry; write enable is tied off when SKID=0 so it folds away.
  pipe_stage_reg_register #(.SIZE(WIDTH), .RST_VALUE(NOP_VALUE)) u_skid (
    .clk(clk), .rst(kill), .en(skid_en & SKID), .d(in_data), .q(skid_q)
  );

  // Registered ready: precomputed from next state, so no out_ready->in_ready path.
  pipe_stage_reg_register #(.SIZE(1), .RST_VALUE(1'b1)) u_rdy (
    .clk(clk), .rst(kill), .en(1'b1), .d(state_nxt != PS_TWO), .q(rdy_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic         fl1 = 0, iv1 = 0, or1 = 0;
  logic [W-1:0] id1 = '0;
  logic         ir1, ov1;
  logic [W-1:0] od1;
  logic [1:0]   oc1;
  // SKID=0 instance
  logic         fl0 = 0, iv0 = 0, or0 = 0;
  logic [W-1:0] id0 = '0;
  logic         ir0, ov0;
  logic [W-1:0] od0;
  logic [1:0]   oc0;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(oc1)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(oc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected packing: {valid, occupancy, in_ready, data}
  task automatic test_reset();
    rst = 1; iv1 = 1; id1 = 16'h1234; iv0 = 1; id0 = 16'h1234;
    or1 = 0; or0 = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({ov1, oc1, od1} !== {1'b0, 2'd0, 16'h0000}) begin
        bad++; $display("FAIL reset1_c%0d got v=%b occ=%0d d=%h want v=0 occ=0 d=0000", c, ov1, oc1, od1);
      end
      total++;
      if ({ov0, oc0, od0} !== {1'b0, 2'd0, 16'h0000}) begin
        bad++; $display("FAIL reset0_c%0d got v=%b occ=%0d d=%h want v=0 occ=0 d=0000", c, ov0, oc0, od0);
      end
    end
    rst = 0; iv1 = 0; iv0 = 0;
    total++;
    if ({ir1, ir0} !== 2'b11) begin
      bad++; $display("FAIL reset_ready got rdy1=%b rdy0=%b want 1 1", ir1, ir0);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] e;
    or1 = 1;
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1; id1 = W'(i);
      tick();
      e = W'(i);
      total++;
      if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd1, 1'b1, e}) begin
        bad++; $display("FAIL stream_%0d got v=%b occ=%0d rdy=%b d=%h want v=1 occ=1 rdy=1 d=%h", i, ov1, oc1, ir1, od1, e);
      end
    end
    iv1 = 0;
    tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b0, 2'd0, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL stream_drain got v=%b occ=%0d rdy=%b d=%h want v=0 occ=0 rdy=1 d=0000", ov1, oc1, ir1, od1);
    end
  endtask

  task automatic test_backpressure();
    or1 = 0; iv1 = 1; id1 = 16'h000A;
    tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd1, 1'b1, 16'h000A}) begin
      bad++; $display("FAIL bp_pushA got v=%b occ=%0d rdy=%b d=%h want 1 1 1 000a", ov1, oc1, ir1, od1);
    end
    id1 = 16'h000B;
    tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd2, 1'b0, 16'h000A}) begin
      bad++; $display("FAIL bp_pushB got v=%b occ=%0d rdy=%b d=%h want 1 2 0 000a", ov1, oc1, ir1, od1);
    end
    iv1 = 0;
    repeat (3) tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd2, 1'b0, 16'h000A}) begin
      bad++; $display("FAIL bp_hold got v=%b occ=%0d rdy=%b d=%h want 1 2 0 000a", ov1, oc1, ir1, od1);
    end
    or1 = 1;
    tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd1, 1'b1, 16'h000B}) begin
      bad++; $display("FAIL bp_popA got v=%b occ=%0d rdy=%b d=%h want 1 1 1 000b", ov1, oc1, ir1, od1);
    end
    iv1 = 1; id1 = 16'h000C;
    tick();
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b1, 2'd1, 1'b1, 16'h000C}) begin
      bad++; $display("FAIL bp_pushC got v=%b occ=%0d rdy=%b d=%h want 1 1 1 000c", ov1, oc1, ir1, od1);
    end
    iv1 = 0;
    tick();
    total++;
    if ({ov1, oc1, od1} !== {1'b0, 2'd0, 16'h0000}) begin
      bad++; $display("FAIL bp_empty got v=%b occ=%0d d=%h want 0 0 0000", ov1, oc1, od1);
    end
  endtask

  task automatic test_flush();
    or1 = 0; iv1 = 1; id1 = 16'h000A;
    tick();
    id1 = 16'h000B;
    tick();
    total++;
    if (oc1 !== 2'd2) begin
      bad++; $display("FAIL flush_pre got occ=%0d want 2", oc1);
    end
    fl1 = 1; id1 = 16'h000C;
    tick();
    fl1 = 0; iv1 = 0;
    total++;
    if ({ov1, oc1, ir1, od1} !== {1'b0, 2'd0, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL flush_kill got v=%b occ=%0d rdy=%b d=%h want 0 0 1 0000", ov1, oc1, ir1, od1);
    end
    or1 = 1;
    tick();
    total++;
    if ({ov1, oc1, od1} !== {1'b0, 2'd0, 16'h0000}) begin
      bad++; $display("FAIL flush_drop got v=%b occ=%0d d=%h want 0 0 0000", ov1, oc1, od1);
    end
  endtask

  task automatic test_skid0();
    or0 = 0; iv0 = 1; id0 = 16'h0033;
    tick();
    total++;
    if ({ov0, oc0, od0} !== {1'b1, 2'd1, 16'h0033}) begin
      bad++; $display("FAIL s0_push got v=%b occ=%0d d=%h want 1 1 0033", ov0, oc0, od0);
    end
    id0 = 16'h0044;
    total++;
    if (ir0 !== 1'b0) begin
      bad++; $display("FAIL s0_stall_rdy got rdy=%b want 0", ir0);
    end
    tick();
    total++;
    if ({ov0, oc0, od0} !== {1'b1, 2'd1, 16'h0033}) begin
      bad++; $display("FAIL s0_hold got v=%b occ=%0d d=%h want 1 1 0033", ov0, oc0, od0);
    end
    or0 = 1; id0 = 16'h0055;
    #1;
    total++;
    if (ir0 !== 1'b1) begin
      bad++; $display("FAIL s0_pass_rdy got rdy=%b want 1", ir0);
    end
    tick();
    total++;
    if ({ov0, oc0, od0} !== {1'b1, 2'd1, 16'h0055}) begin
      bad++; $display("FAIL s0_replace got v=%b occ=%0d d=%h want 1 1 0055", ov0, oc0, od0);
    end
  endtask

  task automatic test_drain();
    or0 = 1; iv0 = 1; id0 = 16'h0077;
    tick();
    total++;
    if ({ov0, od0} !== {1'b1, 16'h0077}) begin
      bad++; $display("FAIL drain_load got v=%b d=%h want 1 0077", ov0, od0);
    end
    iv0 = 0;
    tick();
    total++;
    if ({ov0, oc0, ir0, od0} !== {1'b0, 2'd0, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL drain_empty got v=%b occ=%0d rdy=%b d=%h want 0 0 1 0000", ov0, oc0, ir0, od0);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
